// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the dmem_arbiter data-memory port controller.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0100_0000;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [1:0]  size;
    logic        sign;
  } req_t;

  // Number of bytes touched by an access; 33 bits so range math never wraps.
  function automatic logic [32:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 33'd1;
      SIZE_HALF: return 33'd2;
      default:   return 33'd4;
    endcase
  endfunction

endpackage

// File: rtl/dmem_rr_arbiter.sv
// Two-way grant generator. Round-robin by default; defining
// DMEM_ARB_FIXED_PRIORITY_EN makes port 0 always win and drops last_grant.
module dmem_rr_arbiter (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);

`ifdef DMEM_ARB_FIXED_PRIORITY_EN
  logic unused_inputs;
  assign unused_inputs = &{1'b0, clock, reset, accept};

  assign grant[0] = valid[0];
  assign grant[1] = valid[1] & ~valid[0];
`else
  // Index of the most recently accepted port; resets to 1 so port 0 wins first.
  logic last_grant_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_reg <= 1'b1;
    end else if (accept) begin
      last_grant_reg <= grant[1];
    end
  end

  assign grant[0] = valid[0] & (~valid[1] | last_grant_reg);
  assign grant[1] = valid[1] & (~valid[0] | ~last_grant_reg);
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port request/response controller sharing one data-memory port.
// Optional build macro: DMEM_ARB_FIXED_PRIORITY_EN (port 0 always wins ties).
`ifndef MEM_DEPTH
`define MEM_DEPTH 32'h0001_0000
`endif

module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter logic [31:0] DEPTH_BYTES = `MEM_DEPTH
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        p0_req_valid,
  output logic        p0_req_ready,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic        p0_we,
  input  logic [1:0]  p0_size,
  input  logic        p0_sign,
  output logic        p0_rsp_valid,
  output logic [31:0] p0_rsp_data,
  output logic        p0_rsp_err,

  input  logic        p1_req_valid,
  output logic        p1_req_ready,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic        p1_we,
  input  logic [1:0]  p1_size,
  input  logic        p1_sign,
  output logic        p1_rsp_valid,
  output logic [31:0] p1_rsp_data,
  output logic        p1_rsp_err,

  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic        mem_read_write,
  output logic        mem_is_sign,
  output logic [1:0]  mem_access_size,
  input  logic [31:0] mem_data_out
);

  state_t      state_reg, state_next;
  req_t        req_reg, sel_req;
  logic        port_reg, err_reg;
  logic [31:0] rsp_data_reg;

  logic [1:0]  valid, grant, ready, rsp_valid, rsp_err;
  logic [31:0] rsp_data [2];
  logic        accept, sel_err;
  logic [32:0] last_byte, limit;

  assign valid  = {p1_req_valid, p0_req_valid};
  assign accept = |(valid & ready);

  dmem_rr_arbiter u_arb (
    .clock  (clock),
    .reset  (reset),
    .valid  (valid),
    .accept (accept),
    .grant  (grant)
  );

  always_comb begin
    if (grant[1]) begin
      sel_req = '{addr: p1_addr, wdata: p1_wdata, we: p1_we, size: p1_size, sign: p1_sign};
    end else begin
      sel_req = '{addr: p0_addr, wdata: p0_wdata, we: p0_we, size: p0_size, sign: p0_sign};
    end
  end

  assign last_byte = {1'b0, sel_req.addr} + size_bytes(sel_req.size) - 33'd1;
  assign limit     = {1'b0, BASE_ADDR} + {1'b0, DEPTH_BYTES} - 33'd1;

  assign sel_err = (sel_req.size == SIZE_ILLEGAL)
                 | ((sel_req.size == SIZE_HALF) & sel_req.addr[0])
                 | ((sel_req.size == SIZE_WORD) & (sel_req.addr[1:0] != 2'b00))
                 | (sel_req.addr < BASE_ADDR)
                 | (last_byte > limit);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      req_reg      <= '0;
      port_reg     <= 1'b0;
      err_reg      <= 1'b0;
      rsp_data_reg <= '0;
    end else begin
      if (accept) begin
        req_reg  <= sel_req;
        port_reg <= grant[1];
        err_reg  <= sel_err;
      end
      if (state_reg == ACCESS) begin
        rsp_data_reg <= (!err_reg && !req_reg.we) ? mem_data_out : 32'h0;
      end
    end
  end

  // Memory sits at the idle pattern except during a clean ACCESS cycle; reset
  // kills the write strobe combinationally so an interrupted store never commits.
  always_comb begin
    mem_address     = BASE_ADDR;
    mem_data_in     = 32'h0;
    mem_read_write  = 1'b0;
    mem_is_sign     = 1'b0;
    mem_access_size = SIZE_ILLEGAL;
    if (state_reg == ACCESS && !err_reg) begin
      mem_address     = req_reg.addr;
      mem_data_in     = req_reg.wdata;
      mem_read_write  = req_reg.we & ~reset;
      mem_is_sign     = req_reg.sign;
      mem_access_size = req_reg.size;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      assign ready[gi]     = (state_reg == IDLE) & grant[gi] & ~reset;
      assign rsp_valid[gi] = (state_reg == RESP) & (port_reg == 1'(gi)) & ~reset;
      assign rsp_err[gi]   = rsp_valid[gi] & err_reg;
      assign rsp_data[gi]  = rsp_valid[gi] ? rsp_data_reg : 32'h0;
    end
  endgenerate

  assign p0_req_ready = ready[0];
  assign p1_req_ready = ready[1];
  assign p0_rsp_valid = rsp_valid[0];
  assign p1_rsp_valid = rsp_valid[1];
  assign p0_rsp_err   = rsp_err[0];
  assign p1_rsp_err   = rsp_err[1];
  assign p0_rsp_data  = rsp_data[0];
  assign p1_rsp_data  = rsp_data[1];

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port request/response controller that sequences and shares the single data-memory port (byte-addressed, little-endian, base 0x01000000) between requesters.
  - Port 0 is the core load/store stage.
  - Port 1 is the debug/loader port.
- Arbitrates between the ports, validates alignment and range, drives the memory control signals for exactly one access cycle, and returns registered read data with a status flag.

Parameters:
- BASE_ADDR, 32'h01000000, byte address of memory location 0.
- DEPTH_BYTES, `MEM_DEPTH, number of addressable bytes; valid range is BASE_ADDR to BASE_ADDR+DEPTH_BYTES-1.

Ports:
- clock  in  1  single clock, all state on posedge.
- reset  in  1  synchronous, active-high.
- pN_req_valid  in  1  request present (N = 0, 1).
- pN_req_ready  out  1  request accepted this cycle when valid is also high.
- pN_addr  in  32  byte address.
- pN_wdata  in  32  store data (low bytes used for byte/half).
- pN_we  in  1  1 = store, 0 = load.
- pN_size  in  2  00 byte, 01 half, 10 word; 11 illegal.
- pN_sign  in  1  1 = sign-extend load.
- pN_rsp_valid  out  1  one-cycle response pulse.
- pN_rsp_data  out  32  load data; 0 for stores and errors.
- pN_rsp_err  out  1  misaligned, illegal size, or out of range.
- mem_address  out  32  to memory.
- mem_data_in  out  32  to memory.
- mem_read_write  out  1  1 = write on next posedge.
- mem_is_sign  out  1  to memory.
- mem_access_size  out  2  to memory.
- mem_data_out  in  32  from memory, combinational read.

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Reset forces IDLE.
- IDLE:
  - Grant selects one valid port.
  - pN_req_ready = (state==IDLE) & grantN & ~reset, combinational.
  - On valid&ready, latch addr/wdata/we/size/sign/port and the computed error flag.
  - Go to ACCESS. Stay in IDLE if no request.
- ACCESS (one cycle):
  - If no error: mem_address/data_in/is_sign/access_size are driven from the latches, and mem_read_write = latched we.
  - Loads: capture mem_data_out into the response register at the end of the cycle.
  - If error: mem_read_write=0 and the memory is left untouched.
  - Go to RESP.
- RESP: pN_rsp_valid=1 for the latched port only, with rsp_data and rsp_err. Go to IDLE.
- Latency and throughput: accept at cycle T, rsp_valid at T+2. One transaction per 3 cycles. No back-to-back acceptance.
- Error conditions (any one sets err):
  - size==11.
  - Half with addr[0]!=0.
  - Word with addr[1:0]!=0.
  - addr<BASE_ADDR.
  - addr+bytes-1 > BASE_ADDR+DEPTH_BYTES-1, computed in 33 bits so there is no wrap.
- Idle memory drive (outside ACCESS):
  - mem_read_write=0, mem_address=BASE_ADDR, mem_data_in=0, mem_is_sign=0, mem_access_size=2'b11.
  - Holding size 11 outside ACCESS guarantees a change on mem_access_size at every access start.
- Arbitration: round-robin with a last_grant register, reset value 1 so p0 wins first. last_grant updates only on acceptance. A single valid port is granted immediately.
- Handshake: requesters hold valid and payload stable until ready. Dropping valid before ready is legal, and no transaction occurs.
- Reset values: all rsp_valid/rsp_err/rsp_data = 0, ready = 0 while reset is high, memory outputs at idle drive.
- Reset mid-operation:
  - Reset has priority; mem_read_write is forced 0 combinationally while reset is high, so no write commits.
  - Any pending response is dropped.
  - Ready may assert the cycle after reset deasserts.

Optional Feature:
- DMEM_ARB_FIXED_PRIORITY_EN defined: p0 always wins when both ports are valid; last_grant is removed.
- Undefined: round-robin as above.

Decomposition:
- Package dmem_arb_pkg holds:
  - the state enum (IDLE, ACCESS, RESP);
  - the size constants SIZE_BYTE/SIZE_HALF/SIZE_WORD/SIZE_ILLEGAL;
  - the default BASE_ADDR;
  - a request struct (addr, wdata, we, size, sign).
- One sub-module, dmem_rr_arbiter: a 2-way grant generator with the last_grant register and the priority macro handling. Everything else stays in dmem_arbiter.

Test Plan:
1. After reset, p0 word store 0xDEADBEEF to 0x01000010. Then p0 signed byte load 0x01000013 -> p0_rsp_valid at accept+2, data 0xFFFFFFDE, err 0.
2. p0 unsigned half load 0x01000012 after test 1 -> data 0x0000DEAD. Signed half load 0x01000010 -> 0xFFFFBEEF.
3. Both ports hold valid for 12 cycles -> accepts p0,p1,p0,p1 spaced 3 cycles apart. With DMEM_ARB_FIXED_PRIORITY_EN -> p0 every time.
4. p1 half load 0x01000011; p1 word store 0x00FFFFFC; size 11 -> each gives rsp_err=1, data 0, mem_read_write never 1.
5. Word at BASE_ADDR+DEPTH_BYTES-4 -> err 0. Word at BASE_ADDR+DEPTH_BYTES-2 -> err 1. Address 0xFFFFFFFC -> err 1 (no wrap).
6. Reset asserted in the ACCESS cycle of a store -> mem_read_write 0 that cycle, no rsp_valid, a later read shows the old data, and ready is seen the cycle after reset drops.
